// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 decode opcodes plus load/store width codes, FSM encoding and store helpers
package rv32_pkg;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} lsu_state_e;
  // The unsigned codes only exist for loads; anything undefined is a word access
  function automatic lsu_size_e lsu_size(input logic [2:0] f3, input logic is_load);
    return (f3 == F3_B || (is_load && f3 == F3_BU)) ? SZ_B :
           (f3 == F3_H || (is_load && f3 == F3_HU)) ? SZ_H : SZ_W;
  endfunction
  function automatic logic [3:0] store_be(input lsu_size_e sz, input logic [1:0] off);
    return sz == SZ_B ? 4'b0001 << off : sz == SZ_H ? 4'b0011 << off : 4'b1111;
  endfunction
  function automatic logic [31:0] store_wdata(input lsu_size_e sz, input logic [31:0] d);
    return sz == SZ_B ? {4{d[7:0]}} : sz == SZ_H ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/halfword of a read word and sign- or zero-extends it
module load_align
  import rv32_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word_i[{addr_i, 3'b000} +: 8];
    h = addr_i[1] ? word_i[31:16] : word_i[15:0];
    result_o = funct3_i == F3_B  ? {{24{b[7]}}, b} :
               funct3_i == F3_H  ? {{16{h[15]}}, h} :
               funct3_i == F3_BU ? {24'h0, b} :
               funct3_i == F3_HU ? {16'h0, h} : word_i;
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: M-stage load/store unit driving a single-outstanding ready-handshake data memory
module mem_stage_lsu
  import rv32_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       M_instr,
  input  logic              M_valid,
  input  logic [31:0]       M_alu_result,
  input  logic [DATA_W-1:0] M_store_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] W_load_data,
  output logic              stall_M,
  output logic              misaligned
);
  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cur_addr;
  logic [31:0]       wdata_q, wdata_d, cur_wdata;
  logic [3:0]        be_q, be_d, cur_be;
  logic              we_q, we_d, cur_we;
  logic [2:0]        f3_q, f3_d, cur_f3;
  logic [31:0]       load_q, load_d, aligned;
  logic              mis_q, mis_d;
  logic [2:0]        f3;
  logic              is_ld, is_st, mis_now, go, idle, req, stall, cap;
  lsu_size_e         sz;
  logic              unused_instr;
  assign unused_instr = ^{M_instr[31:15], M_instr[11:7], M_instr[1:0]};
  assign f3      = M_instr[14:12];
  assign is_ld   = M_valid && M_instr[6:2] == OPC_LOAD;
  assign is_st   = M_valid && M_instr[6:2] == OPC_STORE;
  assign sz      = lsu_size(f3, is_ld);
  assign mis_now = (is_ld || is_st) &&
                   (sz == SZ_H ? M_alu_result[0] : sz == SZ_W && |M_alu_result[1:0]);
  assign go      = (is_ld || is_st) && !mis_now;
  load_align u_align (
    .word_i  (dmem_rdata),
    .addr_i  (cur_addr[1:0]),
    .funct3_i(cur_f3),
    .result_o(aligned)
  );
  // In IDLE the request is formed straight from the M stage; in WAIT it replays the captured copy
  always_comb begin
    idle      = state_q == S_IDLE;
    cur_addr  = idle ? M_alu_result[ADDR_W-1:0] : addr_q;
    cur_we    = idle ? is_st : we_q;
    cur_be    = idle ? (is_st ? store_be(sz, M_alu_result[1:0]) : 4'hF) : be_q;
    cur_wdata = idle ? (is_st ? store_wdata(sz, M_store_data) : 32'h0) : wdata_q;
    cur_f3    = idle ? f3 : f3_q;
    req       = idle ? go : 1'b1;
    stall     = req && !dmem_ready;
    state_d   = stall ? S_WAIT : S_IDLE;
    cap       = idle && stall;
    addr_d    = cap ? cur_addr : addr_q;
    we_d      = cap ? cur_we : we_q;
    be_d      = cap ? cur_be : be_q;
    wdata_d   = cap ? cur_wdata : wdata_q;
    f3_d      = cap ? cur_f3 : f3_q;
    load_d    = req && dmem_ready && !cur_we ? aligned : load_q;
    mis_d     = idle && mis_now;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      load_q  <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      load_q  <= load_d;
      mis_q   <= mis_d;
    end
  end
  // Handshake outputs are forced quiet while reset is held, even though IDLE would otherwise decode M
  assign dmem_req    = rst_n && req;
  assign dmem_we     = rst_n && req && cur_we;
  assign stall_M     = rst_n && stall;
  assign dmem_addr   = {cur_addr[ADDR_W-1:2], 2'b00};
  assign dmem_be     = cur_be;
  assign dmem_wdata  = cur_wdata;
  assign W_load_data = load_q;
  assign misaligned  = mis_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized and directed checks of mem_stage_lsu against an arithmetic reference model
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] M_instr = '0;
  logic        M_valid = 1'b0;
  logic [31:0] M_alu_result = '0;
  logic [31:0] M_store_data = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] W_load_data;
  logic        stall_M, misaligned;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_w = '0;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n), .M_instr(M_instr), .M_valid(M_valid),
    .M_alu_result(M_alu_result), .M_store_data(M_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .W_load_data(W_load_data), .stall_M(stall_M),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input bit ld, input logic [2:0] f3);
    if (f3 == 3'd0 || (ld && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (ld && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [4:0] opc, input logic [2:0] f3);
    logic [31:0] r;
    r = $urandom;
    r[14:12] = f3;
    r[6:2] = opc;
    r[1:0] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] exp_be(input int sz, input logic [31:0] a);
    return sz == 4 ? 32'd15 : 32'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] d);
    return sz == 1 ? (d % 256) * 32'h01010101 : sz == 2 ? (d % 65536) * 32'h00010001 : d;
  endfunction

  function automatic logic [31:0] ld_result(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] f3);
    int sz;
    logic [31:0] v;
    sz = size_of(1'b1, f3);
    v = rd >> (8 * (a % 4));
    if (sz == 1) begin
      v = v % 256;
      if (f3 == 3'd0 && v >= 128) v = v - 256;
    end else if (sz == 2) begin
      v = v % 65536;
      if (f3 == 3'd1 && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  task automatic do_op(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd, input int dly);
    int sz;
    sz = size_of(ld, f3);
    M_valid = 1'b1;
    M_instr = mk_instr(ld ? 5'b00000 : 5'b01000, f3);
    M_alu_result = a;
    M_store_data = d;
    for (int c = 0; c <= dly; c++) begin
      dmem_ready = (c == dly);
      dmem_rdata = (c == dly) ? rd : $urandom;
      @(negedge clk);
      check("req", 32'(dmem_req), 32'd1);
      check("we", 32'(dmem_we), 32'(!ld));
      check("addr", dmem_addr, a & ~32'h3);
      check("be", 32'(dmem_be), ld ? 32'd15 : exp_be(sz, a));
      if (!ld) check("wdata", dmem_wdata, exp_wdata(sz, d));
      check("stall", 32'(stall_M), 32'(c < dly));
      @(posedge clk);
      #1;
      if (dly > 0 && c == 0) begin
        M_instr = $urandom;
        M_alu_result = $urandom;
        M_store_data = $urandom;
      end
    end
    if (ld) exp_w = ld_result(rd, a, f3);
    dmem_ready = 1'b0;
    M_valid = 1'b0;
    @(negedge clk);
    check("wload", W_load_data, exp_w);
    check("mis_quiet", 32'(misaligned), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_mis(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    M_valid = 1'b1;
    M_instr = mk_instr(ld ? 5'b00000 : 5'b01000, f3);
    M_alu_result = a;
    M_store_data = $urandom;
    dmem_ready = 1'($urandom);
    @(negedge clk);
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_stall", 32'(stall_M), 32'd0);
    @(posedge clk);
    #1;
    M_valid = 1'b0;
    @(negedge clk);
    check("mis_pulse", 32'(misaligned), 32'd1);
    check("mis_wload", W_load_data, exp_w);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mis_drop", 32'(misaligned), 32'd0);
    @(posedge clk);
    #1;
    dmem_ready = 1'b0;
  endtask

  task automatic do_idle(input bit v, input logic [4:0] opc);
    M_valid = v;
    M_instr = mk_instr(opc, 3'($urandom));
    M_alu_result = $urandom;
    dmem_ready = 1'b1;
    dmem_rdata = $urandom;
    @(negedge clk);
    check("idle_req", 32'(dmem_req), 32'd0);
    check("idle_stall", 32'(stall_M), 32'd0);
    @(posedge clk);
    #1;
    M_valid = 1'b0;
    dmem_ready = 1'b0;
    @(negedge clk);
    check("idle_wload", W_load_data, exp_w);
    check("idle_mis", 32'(misaligned), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_random(input int n);
    bit ld;
    logic [2:0] f3;
    logic [31:0] a;
    logic [4:0] opc;
    int sz;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        ld = 1'($urandom);
        f3 = 3'($urandom);
        sz = size_of(ld, f3);
        a = $urandom;
        if ($urandom_range(0, 4) != 0) a = a - a % sz;
        if (a % sz != 0) do_mis(ld, f3, a);
        else do_op(ld, f3, a, $urandom, $urandom,
                   $urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 4));
      end else if ($urandom_range(0, 1) == 0) begin
        do_idle(1'b0, $urandom_range(0, 1) == 0 ? 5'b00000 : 5'b01000);
      end else begin
        do opc = 5'($urandom); while (opc == 5'b00000 || opc == 5'b01000);
        do_idle(1'b1, opc);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    M_valid = 1'b1;
    M_instr = mk_instr(5'b00000, 3'd2);
    M_alu_result = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_stall", 32'(stall_M), 32'd0);
    check("rst_wload", W_load_data, 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    M_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(1'b0, 3'd0, 32'h103, 32'h000000A5, 32'h0, 0);
    do_op(1'b1, 3'd0, 32'h102, 32'h0, 32'h00800000, 0);
    check("lb_value", W_load_data, 32'hFFFFFF80);
    do_op(1'b1, 3'd4, 32'h102, 32'h0, 32'h00800000, 0);
    check("lbu_value", W_load_data, 32'h00000080);
    do_op(1'b1, 3'd2, 32'h200, 32'h0, 32'hCAFEF00D, 3);
    check("lw_value", W_load_data, 32'hCAFEF00D);
    do_mis(1'b1, 3'd1, 32'h201);
    M_valid = 1'b1;
    M_instr = mk_instr(5'b01000, 3'd2);
    M_alu_result = 32'h300;
    M_store_data = $urandom;
    dmem_ready = 1'b0;
    @(negedge clk);
    check("sw_stall0", 32'(stall_M), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("sw_wait_req", 32'(dmem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_wait_req", 32'(dmem_req), 32'd0);
    check("rst_wait_stall", 32'(stall_M), 32'd0);
    check("rst_wait_we", 32'(dmem_we), 32'd0);
    M_valid = 1'b0;
    exp_w = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req", 32'(dmem_req), 32'd0);
    check("post_rst_stall", 32'(stall_M), 32'd0);
    check("post_rst_wload", W_load_data, 32'd0);
    @(posedge clk);
    #1;
    do_op(1'b1, 3'd5, 32'h402, 32'h0, 32'h9ABC1234, 1);
    do_idle(1'b0, 5'b00000);
    run_random(300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_lsu.md
MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, data-memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, data-memory word width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port M_instr, input, 32, instruction currently in the M stage.
REQ-006 SHALL have port M_valid, input, 1, M_instr is a real instruction and not a bubble or flush.
REQ-007 SHALL have port M_alu_result, input, 32, effective address from the X-stage ALU.
REQ-008 SHALL have port M_store_data, input, 32, rs2 value, already bypassed.
REQ-009 SHALL have ports dmem_req and dmem_we, output, 1 each, request and write-enable.
REQ-010 SHALL have ports dmem_addr, output, ADDR_W, and dmem_wdata, output, 32, with dmem_addr word-aligned (bits [1:0]=0).
REQ-011 SHALL have port dmem_be, output, 4, byte enables.
REQ-012 SHALL have port dmem_ready, input, 1, memory accepts and completes the request this cycle.
REQ-013 SHALL have port dmem_rdata, input, 32, read word, valid when dmem_ready=1.
REQ-014 SHALL have port W_load_data, output, 32, registered, sign- or zero-extended load result.
REQ-015 SHALL have port stall_M, output, 1, freeze F/D/X/M pipeline registers.
REQ-016 SHALL have port misaligned, output, 1, registered one-cycle exception pulse.

Function
REQ-017 SHALL treat opcode bits [6:2]=00000 as a load and 01000 as a store; all other opcodes, and M_valid=0, SHALL produce no request.
REQ-018 SHALL use funct3 decoding: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101; any other funct3 on a load/store SHALL be treated as a word access.
REQ-019 SHALL assert misaligned, with no request issued, when a halfword access has addr[0]=1 or a word access has addr[1:0]!=0.
REQ-020 SHALL implement FSM states IDLE and WAIT.
REQ-021 In IDLE, for an aligned memory op, dmem_req SHALL assert combinationally in the same cycle.
REQ-022 In IDLE, if dmem_ready=1 in that cycle, the FSM SHALL stay in IDLE and stall_M SHALL be 0; otherwise it SHALL go to WAIT and stall_M SHALL be 1.
REQ-023 In WAIT, dmem_req and stall_M SHALL be held at 1, with addr/we/be/wdata taken from registers captured on IDLE->WAIT; on dmem_ready=1 the FSM SHALL return to IDLE and stall_M SHALL drop in that same cycle.
REQ-024 Store byte enables SHALL be: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111.
REQ-025 Store data SHALL be replicated: SB {4{d[7:0]}}; SH {2{d[15:0]}}; SW d.
REQ-026 Loads SHALL drive dmem_be=1111.
REQ-027 Load formatting SHALL select the byte or halfword by the captured addr[1:0] and sign-extend for LB/LH or zero-extend for LBU/LHU.
REQ-028 W_load_data SHALL register the formatted value on the cycle dmem_ready=1, giving one-cycle latency; it SHALL hold otherwise.
REQ-029 Stores and non-memory instructions SHALL leave W_load_data unchanged.
REQ-030 When dmem_ready=1 with no outstanding request, it SHALL be ignored.
REQ-031 A change of M_instr while in WAIT SHALL be ignored; the captured request SHALL complete.

Reset
REQ-032 On rst_n=0 the FSM SHALL go to IDLE immediately, including mid-WAIT, and the pending request SHALL be dropped.
REQ-033 Reset values SHALL be: W_load_data=0, misaligned=0, captured address/data/be=0.
REQ-034 During reset, dmem_req, dmem_we and stall_M SHALL be 0.

Structure
REQ-035 Opcode constants (LOAD 00000, STORE 01000), funct3 width codes and FSM state encodings SHALL live in the shared rv32 package, together with the existing decode opcodes.
REQ-036 Load extraction/extension SHALL be one combinational sub-module, load_align (inputs: word, addr[1:0], funct3; output: 32-bit result).

Verification
REQ-037 A bench SHALL cover SB at addr 0x103, data 0x000000A5, with ready same cycle -> dmem_addr 0x100, be 1000, wdata 0xA5A5A5A5, stall_M 0.
REQ-038 A bench SHALL cover LB at addr 0x102, rdata 0x00800000 -> W_load_data 0xFFFFFF80; and LBU at the same address -> 0x00000080.
REQ-039 A bench SHALL cover LW at 0x200 with ready delayed 3 cycles -> stall_M high for exactly 3 cycles, req held with a stable address, and W_load_data = rdata the cycle after ready.
REQ-040 A bench SHALL cover LH at 0x201 -> no dmem_req, misaligned=1 for one cycle, stall_M 0.
REQ-041 A bench SHALL cover rst_n asserted in WAIT of an SW -> dmem_req and stall_M drop immediately, and the FSM is in IDLE after release.
REQ-042 A bench SHALL cover M_valid=0 with a load opcode -> no request and W_load_data unchanged.
